// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Every bit is held for Prescale clocks; Prescale=0 means 64 clocks per bit.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [5:0]            r_edge_cnt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_parity;
  logic [5:0]            r_prescale;
  logic                  r_tx;
  logic                  r_busy;

  logic [5:0]            w_presc_m1;
  logic                  w_bit_done;
  logic [5:0]            w_next_cnt;
  logic [CNT_W-1:0]      w_bit_nxt;

  // Prescale=0 makes w_presc_m1 = 63, so the 6-bit counter's natural wrap gives 64 clocks.
  assign w_presc_m1 = r_prescale - 6'd1;
  assign w_bit_done = (r_edge_cnt == w_presc_m1);
  assign w_next_cnt = w_bit_done ? 6'd0 : r_edge_cnt + 6'd1;
  assign w_bit_nxt  = r_bit_cnt + 1'b1;

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_parity   <= 1'b0;
      r_prescale <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          if (Data_Valid) begin
            r_data     <= P_DATA;
            r_par_en   <= PAR_EN;
            r_parity   <= (^P_DATA) ^ PAR_TYP;
            r_prescale <= Prescale;
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          r_edge_cnt <= w_next_cnt;
          if (w_bit_done) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_tx      <= r_data[0];
          end
        end
        S_DATA: begin
          r_edge_cnt <= w_next_cnt;
          if (w_bit_done) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
              r_tx    <= r_par_en ? r_parity : 1'b1;
            end else begin
              r_bit_cnt <= w_bit_nxt;
              r_tx      <= r_data[w_bit_nxt];
            end
          end
        end
        S_PARITY: begin
          r_edge_cnt <= w_next_cnt;
          if (w_bit_done) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
        S_STOP: begin
          r_edge_cnt <= w_next_cnt;
          if (w_bit_done) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line waveform built from the frame rules as a queue of bits,
// each bit expected for Prescale clocks, compared cycle by cycle.
module tb_uart_tx;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [5:0]    Prescale = 6'd0;
  logic          TX_OUT;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_tx"}, TX_OUT, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      tick();
    end
  endtask

  // Present a word and clock it in; afterwards the bench sits in the first frame cycle.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic [5:0] p, input logic hold);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = p;
    Data_Valid = 1'b1;
    tick();
    if (!hold) Data_Valid = 1'b0;
  endtask

  // Reference frame: start, data LSB first, optional parity, stop; each bit for Prescale clocks.
  // inject_at: frame cycle where a competing word (and altered config) is presented for one clock.
  // abort_at : frame cycle where reset is asserted and the frame is abandoned.
  task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                           input logic [5:0] p, input int inject_at, input int abort_at);
    logic bits[$];
    int   nclk;
    int   c;
    nclk = (p == 6'd0) ? 64 : int'(p);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((($countones(d) % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    c = 0;
    foreach (bits[b]) begin
      for (int k = 0; k < nclk; k++) begin
        if (c == abort_at) begin
          rst = 1'b0;
          #1;
          check("async_rst_tx", TX_OUT, 1'b1);
          check("async_rst_busy", busy, 1'b0);
          return;
        end
        if (inject_at >= 0 && c == inject_at) begin
          P_DATA     = 8'h3C;
          PAR_EN     = ~pe;
          PAR_TYP    = ~pt;
          Prescale   = p + 6'd3;
          Data_Valid = 1'b1;
        end else if (inject_at >= 0 && c == inject_at + 1) begin
          Data_Valid = 1'b0;
        end
        check($sformatf("tx_d%02h_bit%0d_clk%0d", d, b, k), TX_OUT, bits[b]);
        check($sformatf("busy_d%02h_bit%0d_clk%0d", d, b, k), busy, 1'b1);
        tick();
        c++;
      end
    end
    if (inject_at >= 0) Data_Valid = 1'b0;
    check($sformatf("end_tx_d%02h", d), TX_OUT, 1'b1);
    check($sformatf("end_busy_d%02h", d), busy, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
    logic [5:0]    p;

    // Reset held with random inputs, including Data_Valid, must keep the line idle.
    #2 rst = 1'b0;
    #1;
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      P_DATA     = DW'($urandom);
      Data_Valid = 1'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      Prescale   = 6'($urandom);
      tick();
      check("rst_hold_tx", TX_OUT, 1'b1);
      check("rst_hold_busy", busy, 1'b0);
    end
    Data_Valid = 1'b0;
    rst = 1'b1;
    check_idle("post_rst_idle", 100);

    // Basic frame without parity.
    send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    run_frame(8'hA5, 1'b0, 1'b0, 6'd8, -1, -1);
    check_idle("basic_idle", 5);

    // Parity variants at Prescale=16.
    send(8'h07, 1'b1, 1'b0, 6'd16, 1'b0);
    run_frame(8'h07, 1'b1, 1'b0, 6'd16, -1, -1);
    check_idle("par_even_idle", 3);
    send(8'h07, 1'b1, 1'b1, 6'd16, 1'b0);
    run_frame(8'h07, 1'b1, 1'b1, 6'd16, -1, -1);
    check_idle("par_odd_idle", 3);
    send(8'h00, 1'b1, 1'b1, 6'd16, 1'b0);
    run_frame(8'h00, 1'b1, 1'b1, 6'd16, -1, -1);
    check_idle("par_odd_zero_idle", 3);

    // Busy protection: a second request mid-frame, with altered config, is dropped.
    send(8'h96, 1'b0, 1'b0, 6'd8, 1'b0);
    run_frame(8'h96, 1'b0, 1'b0, 6'd8, 40, -1);
    check_idle("busy_protect_idle", 100);

    // Back-to-back with Data_Valid held: one idle clock between frames.
    send(8'h55, 1'b0, 1'b0, 6'd4, 1'b1);
    P_DATA = 8'hAA;
    run_frame(8'h55, 1'b0, 1'b0, 6'd4, -1, -1);
    tick();
    Data_Valid = 1'b0;
    run_frame(8'hAA, 1'b0, 1'b0, 6'd4, -1, -1);
    check_idle("b2b_idle", 5);

    // Reset during data bit 3 truncates the frame; the next request is a clean frame.
    d = DW'($urandom);
    send(d, 1'b0, 1'b0, 6'd8, 1'b0);
    run_frame(d, 1'b0, 1'b0, 6'd8, -1, 8 + 3 * 8 + 2);
    tick();
    check("rst_mid_hold_tx", TX_OUT, 1'b1);
    check("rst_mid_hold_busy", busy, 1'b0);
    rst = 1'b1;
    check_idle("rst_mid_idle", 3);
    d = DW'($urandom);
    send(d, 1'b1, 1'b0, 6'd8, 1'b0);
    run_frame(d, 1'b1, 1'b0, 6'd8, -1, -1);
    check_idle("rst_mid_clean_idle", 2);

    // Prescale boundaries.
    d = DW'($urandom);
    send(d, 1'b0, 1'b0, 6'd1, 1'b0);
    run_frame(d, 1'b0, 1'b0, 6'd1, -1, -1);
    check_idle("presc1_idle", 2);
    d = DW'($urandom);
    send(d, 1'b0, 1'b0, 6'd0, 1'b0);
    run_frame(d, 1'b0, 1'b0, 6'd0, -1, -1);
    check_idle("presc0_idle", 2);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      d  = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      p  = 6'($urandom_range(1, 7));
      send(d, pe, pt, p, 1'b0);
      run_frame(d, pe, pt, p, -1, -1);
      check_idle("rand_idle", int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serializes one 8-bit word per frame onto TX_OUT.
- Frame: start bit, data LSB first, optional parity bit, one stop bit.
- Runs on the same oversampled clock and Prescale as the UART receiver, so each bit is held for Prescale clocks.
- Sits between the system-side data source and the serial line. Its frame format matches the receiver's (PAR_EN, PAR_TYP, Prescale).

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  system/oversampling clock.
- rst  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word to send.
- Data_Valid  input  1  request pulse/level; P_DATA is valid while high.
- PAR_EN  input  1  1 = parity bit inserted after data.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  6  clocks per bit.
- TX_OUT  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst low, async): state=IDLE, TX_OUT=1, busy=0, all counters and data/config registers cleared.
- All outputs are registered; there is no combinational path from inputs to TX_OUT or busy.
- States and transitions:
  - IDLE: TX_OUT=1, busy=0. On a clock edge with Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and Prescale; compute the parity bit; go to START.
  - START: TX_OUT=0 for Prescale clocks, then go to DATA.
  - DATA: TX_OUT=data[bit_cnt], bit_cnt 0..DATA_WIDTH-1, each bit held Prescale clocks. After the last bit, go to PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: TX_OUT = ^data when PAR_TYP=0, ~(^data) when PAR_TYP=1; held Prescale clocks; then STOP.
  - STOP: TX_OUT=1 for Prescale clocks, then IDLE.
- Timing:
  - Data_Valid sampled high at edge k: TX_OUT=0 and busy=1 from edge k (visible in the cycle after k).
  - busy falls at the same edge TX_OUT enters IDLE.
- Edge counter: 6-bit, increments every clock in non-IDLE states, wraps to 0 when equal to Prescale_latched-1 and advances the bit/state. Prescale=0 behaves as 64 clocks per bit via the natural wrap. Prescale=1 gives one clock per bit.
- Frame length is (DATA_WIDTH+2+PAR_EN)*Prescale clocks exactly.
- Data_Valid while busy=1 is ignored; that word is not queued.
- The earliest next acceptance is the edge at which the state is IDLE, i.e. the first edge after the STOP bit completes.
- Data_Valid held high continuously gives back-to-back frames separated by exactly 1 idle clock (TX_OUT=1).
- Changing P_DATA, PAR_EN, PAR_TYP or Prescale mid-frame has no effect on the current frame; only the latched copies are used.
- Reset asserted mid-frame: immediate return to IDLE, TX_OUT=1, busy=0; the frame is truncated.

Test Plan:
- Reset: rst=0 with random inputs -> TX_OUT=1, busy=0. Release, Data_Valid=0 for 100 clocks -> TX_OUT stays 1.
- Basic frame, no parity: Prescale=8, PAR_EN=0, P_DATA=0xA5, 1-clock Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 clocks; busy high 80 clocks; then IDLE.
- Parity: Prescale=16, PAR_EN=1, P_DATA=0x07.
  - PAR_TYP=0 -> parity bit 1; frame 176 clocks.
  - PAR_TYP=1 -> parity bit 0.
  - Repeat with P_DATA=0x00, PAR_TYP=1 -> parity bit 1.
- Busy protection: a second Data_Valid pulse with P_DATA=0x3C at mid-frame -> ignored; only the first word appears; no second frame.
- Back-to-back: Data_Valid held high, P_DATA=0x55 then 0xAA, Prescale=4, PAR_EN=0 -> two 40-clock frames with exactly one idle clock (TX_OUT=1) between them.
- Mid-frame reset and boundary Prescale:
  - rst pulsed low during data bit 3 -> TX_OUT=1, busy=0 asynchronously; next Data_Valid starts a clean frame.
  - Prescale=1 -> 10-clock frame.
  - Prescale=0 -> 640-clock frame.
